rom_load_ctrl: RTL and testbench

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

---
 rtl/rom_load_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_ctrl.sv
// Boot-time instruction ROM loader: packs a byte stream into 32-bit words, writes them
// to the ROM, holds the core in reset until the image settles, and arbitrates debug writes.
module rom_load_ctrl #(
  parameter int ROM_DEPTH   = 4096,
  parameter int ADDR_W      = 12,
  parameter int RELEASE_DLY = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RELEASE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [7:0]      REL_LAST = 8'(RELEASE_DLY - 1);

  state_t            state;
  logic [1:0]        idx;
  logic [23:0]       asm_q;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic [ADDR_W-1:0] hold_addr;
  logic [31:0]       hold_wdata;
  logic [7:0]        rel_cnt;
  logic              accept;
  logic              full;

  // Lanes above the newest byte are zeroed so a short final word never carries stale bytes.
  function automatic logic [31:0] pack_word(input logic [23:0] lanes, input logic [7:0] b,
                                            input logic [1:0] lane);
    logic [31:0] w;
    case (lane)
      2'd0:    w = {24'd0, b};
      2'd1:    w = {16'd0, b, lanes[7:0]};
      2'd2:    w = {8'd0, b, lanes[15:0]};
      default: w = {b, lanes};
    endcase
    return w;
  endfunction

  assign accept = byte_valid_i && byte_ready_o;
  assign full   = (words_o == FULL);

  // ROM port: the registered loader write wins; otherwise debug; otherwise hold last value.
  always_comb begin
    dbg_gnt_o   = dbg_req_i && !ld_we && !rst;
    rom_we_o    = ld_we || dbg_gnt_o;
    rom_addr_o  = hold_addr;
    rom_wdata_o = hold_wdata;
    if (ld_we) begin
      rom_addr_o  = ld_addr;
      rom_wdata_o = ld_wdata;
    end else if (dbg_gnt_o) begin
      rom_addr_o  = dbg_addr_i;
      rom_wdata_o = dbg_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      core_rst_o   <= 1'b1;
      byte_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      words_o      <= '0;
      idx          <= '0;
      rel_cnt      <= '0;
      ld_we        <= 1'b0;
    end else begin
      ld_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start_i) begin
            state        <= LOAD;
            core_rst_o   <= 1'b1;
            byte_ready_o <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            words_o      <= '0;
            idx          <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (full) begin
              err_o  <= 1'b1;
              busy_o <= 1'b0;
              if (byte_last_i) begin
                state        <= IDLE;
                byte_ready_o <= 1'b0;
              end else begin
                state <= DRAIN;
              end
            end else begin
              idx <= idx + 2'd1;
              if (idx == 2'd3 || byte_last_i) begin
                ld_we   <= 1'b1;
                words_o <= words_o + (ADDR_W+1)'(1);
              end
              if (byte_last_i) begin
                byte_ready_o <= 1'b0;
                rel_cnt      <= '0;
                state        <= (idx == 2'd3) ? RELEASE : FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          state   <= RELEASE;
          rel_cnt <= '0;
        end
        RELEASE: begin
          // Counting starts only once the final write cycle has gone by.
          if (!ld_we) begin
            if (rel_cnt == REL_LAST) begin
              state      <= RUN;
              core_rst_o <= 1'b0;
              done_o     <= 1'b1;
              busy_o     <= 1'b0;
            end else begin
              rel_cnt <= rel_cnt + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (accept && byte_last_i) begin
            state        <= IDLE;
            byte_ready_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && accept && !full) begin
      case (idx)
        2'd0:    asm_q[7:0]   <= byte_i;
        2'd1:    asm_q[15:8]  <= byte_i;
        2'd2:    asm_q[23:16] <= byte_i;
        default: ;
      endcase
      if (idx == 2'd3 || byte_last_i) begin
        ld_addr  <= words_o[ADDR_W-1:0];
        ld_wdata <= pack_word(asm_q, byte_i, idx);
      end
    end
    if (rom_we_o) begin
      hold_addr  <= rom_addr_o;
      hold_wdata <= rom_wdata_o;
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: image-level write scoreboard, per-cycle port rules,
// and directed loads with literal expected words and timing.
module tb_rom_load_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DLY   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_i = '0;
  logic          byte_last_i = 1'b0;
  logic          byte_ready_o;
  logic          dbg_req_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [31:0]   dbg_wdata_i = '0;
  logic          dbg_gnt_o;
  logic          rom_we_o;
  logic [AW-1:0] rom_addr_o;
  logic [31:0]   rom_wdata_o;
  logic          core_rst_o, busy_o, done_o, err_o;
  logic [AW:0]   words_o;

  rom_load_ctrl #(.ROM_DEPTH(DEPTH), .ADDR_W(AW), .RELEASE_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
    .byte_last_i(byte_last_i), .byte_ready_o(byte_ready_o), .dbg_req_i(dbg_req_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
    .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o), .rom_wdata_o(rom_wdata_o),
    .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    lg_data[$];
  logic [AW-1:0]  lg_addr[$];
  logic [7:0]     img[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Image model: little-endian words, zero-padded tail, truncated at ROM depth.
  task automatic expect_img();
    int nw;
    logic [31:0] wd;
    nw = (img.size() + 3) / 4;
    if (nw > DEPTH) nw = DEPTH;
    for (int w = 0; w < nw; w++) begin
      wd = '0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < img.size()) wd[8*k +: 8] = img[4*w + k];
      exp_q.push_back({AW'(w), wd});
    end
  endtask

  // Per-cycle checks, sampled late in the low phase after inputs have settled.
  initial begin : cmp
    int cyc = 0;
    int lw_cyc = 0;
    bit have_last = 0;
    logic [AW-1:0] la = '0;
    logic [31:0] ldv = '0;
    logic prev_crst = 1'b1;
    logic [AW+31:0] e;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst) begin
        if (rom_we_o && !dbg_gnt_o) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: got %0h:%0h expected none", rom_addr_o, rom_wdata_o);
          end else begin
            e = exp_q.pop_front();
            chk("loader_write", {rom_addr_o, rom_wdata_o}, e);
          end
          lg_addr.push_back(rom_addr_o);
          lg_data.push_back(rom_wdata_o);
          lw_cyc = cyc;
        end
        if (dbg_gnt_o)
          chk("dbg_write", {dbg_req_i, rom_addr_o, rom_wdata_o}, {1'b1, dbg_addr_i, dbg_wdata_i});
        if (dbg_req_i && !dbg_gnt_o) chk("dbg_blocked_only_by_loader", rom_we_o, 1);
        if (!rom_we_o && have_last) chk("rom_port_hold", {rom_addr_o, rom_wdata_o}, {la, ldv});
        if (rom_we_o) begin have_last = 1; la = rom_addr_o; ldv = rom_wdata_o; end
        chk("core_rst_vs_done", core_rst_o, !done_o);
        if (prev_crst && !core_rst_o) chk("release_delay", cyc - lw_cyc, DLY + 1);
      end
      prev_crst = core_rst_o;
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int t = 0;
    byte_valid_i = 1'b1; byte_i = b; byte_last_i = last;
    while (!byte_ready_o && t < 20) begin @(negedge clk); t++; end
    if (!byte_ready_o) begin
      checks++; failures++;
      $display("FAIL send_timeout: byte_ready_o=0 required=1");
    end
    @(negedge clk);
    byte_valid_i = 1'b0; byte_last_i = 1'b0;
  endtask

  task automatic send_img(input bit last_on_final);
    for (int i = 0; i < img.size(); i++)
      send(img[i], last_on_final && (i == img.size() - 1));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_o && t < 40) begin @(negedge clk); t++; end
    chk("done_reached", done_o, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_core_rst", core_rst_o, 1);
    chk("rst_rom_we", rom_we_o, 0);
    chk("rst_ready", byte_ready_o, 0);
    chk("rst_gnt", dbg_gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_words", words_o, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals();

    // Two full words, last byte on lane 3.
    n0 = lg_data.size();
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    expect_img();
    pulse_start();
    send_img(1);
    wait_done();
    chk("t1_words", words_o, 2);
    chk("t1_word0", lg_data[n0], 32'h0000_0013);
    chk("t1_word1", lg_data[n0+1], 32'h0010_0093);
    chk("t1_addr1", lg_addr[n0+1], 1);
    chk("t1_busy", busy_o, 0);

    // Reload from RUN, short tail flushed with zero padding.
    pulse_start();
    chk("reload_core_rst", core_rst_o, 1);
    chk("reload_words", words_o, 0);
    chk("reload_busy", busy_o, 1);
    chk("reload_ready", byte_ready_o, 1);
    n0 = lg_data.size();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    expect_img();
    send_img(1);
    wait_done();
    chk("t2_word0", lg_data[n0], 32'hDDCC_BBAA);
    chk("t2_word1", lg_data[n0+1], 32'h0000_0011);
    chk("t2_words", words_o, 2);
    chk("t2_err", err_o, 0);

    // Debug request held across a lane-3 acceptance.
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_img();
    pulse_start();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    dbg_addr_i = 2'd3; dbg_wdata_i = 32'hCAFE_F00D; dbg_req_i = 1'b1;
    byte_valid_i = 1'b1; byte_i = 8'h04; byte_last_i = 1'b0;
    #1 chk("dbg_gnt_before_write", dbg_gnt_o, 1);
    @(negedge clk);
    byte_valid_i = 1'b0;
    #1;
    chk("dbg_gnt_in_loader_cycle", dbg_gnt_o, 0);
    chk("loader_port", {rom_we_o, rom_addr_o, rom_wdata_o}, {1'b1, 2'd0, 32'h0403_0201});
    @(negedge clk);
    #1;
    chk("dbg_gnt_after_write", dbg_gnt_o, 1);
    chk("dbg_port", {rom_we_o, rom_addr_o, rom_wdata_o}, {1'b1, 2'd3, 32'hCAFE_F00D});
    dbg_req_i = 1'b0;
    @(negedge clk);
    send(8'h05, 1);
    wait_done();

    // Overflow with last on the dropped byte: straight back to IDLE.
    img.delete();
    for (int i = 0; i < 17; i++) img.push_back(8'(i + 1));
    expect_img();
    pulse_start();
    send_img(1);
    chk("ovf_err", err_o, 1);
    chk("ovf_ready", byte_ready_o, 0);
    chk("ovf_words", words_o, 4);
    chk("ovf_done", done_o, 0);
    for (int i = 0; i < 6; i++) begin
      chk("ovf_core_held", core_rst_o, 1);
      @(negedge clk);
    end

    // Overflow without last: drain, start ignored, exit on last.
    pulse_start();
    chk("err_cleared_by_start", err_o, 0);
    img.delete();
    for (int i = 0; i < 17; i++) img.push_back(8'(8'h20 + i));
    expect_img();
    send_img(0);
    chk("drain_err", err_o, 1);
    chk("drain_ready", byte_ready_o, 1);
    pulse_start();
    chk("drain_start_ignored", words_o, 4);
    send(8'h55, 0);
    send(8'h66, 1);
    chk("drain_exit_ready", byte_ready_o, 0);
    chk("drain_exit_err", err_o, 1);
    chk("drain_exit_core_rst", core_rst_o, 1);
    byte_valid_i = 1'b1; byte_last_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ignores_bytes", byte_ready_o, 0);
    byte_valid_i = 1'b0; byte_last_i = 1'b0;
    chk("idle_words_unchanged", words_o, 4);

    // Reset after one word plus two bytes: no partial write, reload starts at 0.
    img = '{8'h77, 8'h88, 8'h99, 8'hA0};
    expect_img();
    pulse_start();
    send_img(0);
    send(8'hB1, 0);
    send(8'hC2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals();
    n0 = lg_data.size();
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_img();
    pulse_start();
    send_img(1);
    wait_done();
    chk("post_rst_word", lg_data[n0], 32'h4433_2211);
    chk("post_rst_addr", lg_addr[n0], 0);
    chk("post_rst_words", words_o, 1);

    repeat (2) @(negedge clk);
    chk("all_writes_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
